// File: rtl/hier_fanin_collector.sv
// hier_fanin_collector
// Collects result beats from NUM_CHILD child channels into one upstream
// stream. A round-robin arbiter picks among children that are valid and not
// yet finished. A single-entry output register holds the chosen beat. The
// block tracks which children have delivered their final beat and raises
// all_done once every child is finished and the output register is empty.
module hier_fanin_collector #(
    parameter int NUM_CHILD = 5,
    parameter int DATA_W    = 8,
    parameter int ID_W      = 3,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic [NUM_CHILD-1:0]        child_valid,
    input  logic [NUM_CHILD-1:0]        child_last,
    input  logic [NUM_CHILD*DATA_W-1:0] child_data,
    output logic [NUM_CHILD-1:0]        child_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ID_W-1:0]             out_id,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    output logic [NUM_CHILD-1:0]        done_mask,
    output logic                        all_done,
    output logic [CNT_W-1:0]            beat_count
);

    // The internal index is only as wide as needed to name a child. One
    // extra bit lets the wrap-around sum pointer+offset be formed without
    // overflow before it is reduced modulo NUM_CHILD.
    localparam int IDX_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;
    localparam logic [IDX_W:0] NC = (IDX_W+1)'(NUM_CHILD);

    // State registers
    logic                 out_valid_q, out_valid_d;
    logic [ID_W-1:0]      out_id_q, out_id_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;
    logic [NUM_CHILD-1:0] done_mask_q, done_mask_d;
    logic                 all_done_q, all_done_d;
    logic [CNT_W-1:0]     beat_count_q, beat_count_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;

    // Arbitration signals
    logic                 load_en;
    logic [NUM_CHILD-1:0] eligible;
    logic                 grant_valid;
    logic [IDX_W-1:0]     grant;
    logic [IDX_W:0]       rr_idx;
    logic [IDX_W-1:0]     ptr_inc;
    logic [DATA_W-1:0]    sel_data;
    logic                 sel_last;
    logic                 accept;

    // The output register can take a new beat when it is empty or when its
    // current beat leaves upstream in this same cycle.
    assign load_en  = !out_valid_q || out_ready;
    assign eligible = child_valid & ~done_mask_q;

    // Round-robin search: walk the offsets from highest to lowest so that
    // the last hit, the one closest to the pointer, wins.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        rr_idx      = '0;
        for (int k = NUM_CHILD-1; k >= 0; k--) begin
            rr_idx = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (rr_idx >= NC) begin
                rr_idx = rr_idx - NC;
            end
            if (eligible[rr_idx[IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant       = rr_idx[IDX_W-1:0];
            end
        end
    end

    // Ready goes only to the granted child. It is suppressed during reset
    // and clear so that nothing is acknowledged in those cycles.
    always_comb begin
        child_ready = '0;
        for (int i = 0; i < NUM_CHILD; i++) begin
            child_ready[i] = rst_n && !clear && load_en && grant_valid &&
                             (grant == IDX_W'(i));
        end
    end

    // Select the payload and final-beat marker of the granted child.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_CHILD; i++) begin
            if (grant == IDX_W'(i)) begin
                sel_data = child_data[i*DATA_W +: DATA_W];
                sel_last = child_last[i];
            end
        end
    end

    assign accept  = |(child_valid & child_ready);
    assign ptr_inc = (grant == IDX_W'(NUM_CHILD-1)) ? '0 : grant + 1'b1;

    // Next-state logic. A clear restarts the round. Otherwise an accept
    // loads the output register, which may replace a beat leaving in the
    // same cycle. With no accept, a departing beat empties the register.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_id_d     = out_id_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        done_mask_d  = done_mask_q;
        beat_count_d = beat_count_q;
        ptr_d        = ptr_q;
        // Sticky once set. After every child is done nothing can refill the
        // output register, so the condition would hold on its own anyway.
        all_done_d   = all_done_q | ((&done_mask_q) & ~out_valid_q);
        if (clear) begin
            out_valid_d  = 1'b0;
            done_mask_d  = '0;
            beat_count_d = '0;
            ptr_d        = '0;
            all_done_d   = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_id_d    = ID_W'(grant);
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            ptr_d       = ptr_inc;
            if (sel_last) begin
                done_mask_d[grant] = 1'b1;
            end
            if (beat_count_q != {CNT_W{1'b1}}) begin
                beat_count_d = beat_count_q + 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State update. Reset takes priority over everything else and drops
    // any beat that is being held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_id_q     <= '0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            done_mask_q  <= '0;
            all_done_q   <= 1'b0;
            beat_count_q <= '0;
            ptr_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_id_q     <= out_id_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            done_mask_q  <= done_mask_d;
            all_done_q   <= all_done_d;
            beat_count_q <= beat_count_d;
            ptr_q        <= ptr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_id     = out_id_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign done_mask  = done_mask_q;
    assign all_done   = all_done_q;
    assign beat_count = beat_count_q;

endmodule

// File: tb/tb_hier_fanin_collector.sv
// Directed testbench for hier_fanin_collector. A second instance with a
// 4-bit counter shares the same stimulus and is used for saturation checks.
module tb_hier_fanin_collector;

    localparam int NC = 5;
    localparam int DW = 8;
    localparam int IW = 3;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic [NC-1:0]     child_valid;
    logic [NC-1:0]     child_last;
    logic [NC*DW-1:0]  child_data;
    logic              out_ready;

    logic [NC-1:0]     child_ready;
    logic              out_valid;
    logic [IW-1:0]     out_id;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic [NC-1:0]     done_mask;
    logic              all_done;
    logic [15:0]       beat_count;

    logic [NC-1:0]     s_child_ready;
    logic              s_out_valid;
    logic [IW-1:0]     s_out_id;
    logic [DW-1:0]     s_out_data;
    logic              s_out_last;
    logic [NC-1:0]     s_done_mask;
    logic              s_all_done;
    logic [3:0]        s_beat_count;

    int npass = 0;
    int ntot  = 0;

    hier_fanin_collector #(.NUM_CHILD(NC), .DATA_W(DW), .ID_W(IW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .child_valid(child_valid), .child_last(child_last), .child_data(child_data),
        .child_ready(child_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_data(out_data), .out_last(out_last),
        .done_mask(done_mask), .all_done(all_done), .beat_count(beat_count)
    );

    hier_fanin_collector #(.NUM_CHILD(NC), .DATA_W(DW), .ID_W(IW), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .child_valid(child_valid), .child_last(child_last), .child_data(child_data),
        .child_ready(s_child_ready), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_id(s_out_id), .out_data(s_out_data), .out_last(s_out_last),
        .done_mask(s_done_mask), .all_done(s_all_done), .beat_count(s_beat_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst_n       = 1'b0;
        clear       = 1'b0;
        child_valid = '1;
        child_last  = '0;
        out_ready   = 1'b1;
        for (int i = 0; i < NC; i++) child_data[i*DW +: DW] = 8'hC0 + 8'(i);

        // Reset held for two edges with every child requesting
        tick();
        tick();
        chk("rst_ready", 32'(child_ready), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_count", 32'(beat_count), 32'h0);
        chk("rst_done", 32'(done_mask), 32'h0);
        chk("rst_alldone", 32'(all_done), 32'h0);
        chk("rst_id", 32'(out_id), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);

        // Round robin: all valid, upstream always ready
        rst_n = 1'b1;
        settle();
        chk("rr_first_ready", 32'(child_ready), 32'h01);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("rr_valid", 32'(out_valid), 32'h1);
            chk("rr_id", 32'(out_id), 32'(k % 5));
            chk("rr_data", 32'(out_data), 32'h0C0 + 32'(k % 5));
        end
        chk("rr_count7", 32'(beat_count), 32'd7);
        child_valid = '0;
        tick();
        chk("rr_drain_valid", 32'(out_valid), 32'h0);
        chk("rr_drain_count", 32'(beat_count), 32'd7);

        // Backpressure: child 2 sends 0xA5 while upstream stalls
        out_ready   = 1'b0;
        child_valid = 5'b00100;
        child_data[2*DW +: DW] = 8'hA5;
        settle();
        chk("bp_ready_c2", 32'(child_ready), 32'h04);
        tick();
        child_valid = '1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("bp_ready_none", 32'(child_ready), 32'h0);
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_id", 32'(out_id), 32'h2);
            chk("bp_data", 32'(out_data), 32'hA5);
            tick();
        end
        out_ready   = 1'b1;
        child_valid = '0;
        settle();
        chk("bp_still_held", 32'(out_data), 32'hA5);
        tick();
        chk("bp_transferred", 32'(out_valid), 32'h0);
        chk("bp_count", 32'(beat_count), 32'd8);

        // Completion: three beats per child, the third marked last
        clear = 1'b1;
        tick();
        clear = 1'b0;
        child_valid = '1;
        for (int c = 0; c < 15; c++) begin
            child_last = (c >= 10) ? 5'b11111 : 5'b00000;
            settle();
            chk("cmp_ready", 32'(child_ready), 32'(1 << (c % 5)));
            tick();
            chk("cmp_id", 32'(out_id), 32'(c % 5));
            chk("cmp_last", 32'(out_last), (c >= 10) ? 32'h1 : 32'h0);
            if (c == 11) chk("cmp_mask_mid", 32'(done_mask), 32'h03);
        end
        chk("cmp_mask_full", 32'(done_mask), 32'h1F);
        chk("cmp_alldone_early", 32'(all_done), 32'h0);
        settle();
        chk("cmp_done_ignored", 32'(child_ready), 32'h0);
        tick();
        chk("cmp_final_xfer", 32'(out_valid), 32'h0);
        chk("cmp_alldone_wait", 32'(all_done), 32'h0);
        tick();
        chk("cmp_alldone", 32'(all_done), 32'h1);
        chk("cmp_count15", 32'(beat_count), 32'd15);
        tick();
        chk("cmp_alldone_hold", 32'(all_done), 32'h1);
        chk("cmp_still_ignored", 32'(child_ready), 32'h0);

        // Clear mid-round with done_mask=00101 and a held beat
        clear = 1'b1;
        child_last = '0;
        tick();
        clear = 1'b0;
        chk("clr_alldone", 32'(all_done), 32'h0);
        child_valid = 5'b00001;
        child_last  = 5'b00001;
        tick();
        child_valid = 5'b00100;
        child_last  = 5'b00100;
        settle();
        chk("mid_ready_c2", 32'(child_ready), 32'h04);
        tick();
        chk("mid_mask", 32'(done_mask), 32'h05);
        chk("mid_valid", 32'(out_valid), 32'h1);
        chk("mid_count", 32'(beat_count), 32'd2);
        clear       = 1'b1;
        child_valid = '1;
        child_last  = '0;
        settle();
        chk("mid_clr_ready", 32'(child_ready), 32'h0);
        tick();
        clear = 1'b0;
        chk("mid_clr_valid", 32'(out_valid), 32'h0);
        chk("mid_clr_mask", 32'(done_mask), 32'h0);
        chk("mid_clr_count", 32'(beat_count), 32'h0);
        settle();
        chk("mid_restart_ready", 32'(child_ready), 32'h01);
        tick();
        chk("mid_restart_id", 32'(out_id), 32'h0);

        // Saturation of a 4-bit counter over 20 accepts
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 14) chk("sat_at15", 32'(s_beat_count), 32'd15);
        end
        chk("sat_hold", 32'(s_beat_count), 32'd15);
        chk("sat_wide", 32'(beat_count), 32'd20);

        // Reset while a beat is held under backpressure
        out_ready = 1'b0;
        tick();
        chk("rstmid_held", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        tick();
        chk("rstmid_valid", 32'(out_valid), 32'h0);
        chk("rstmid_count", 32'(beat_count), 32'h0);
        chk("rstmid_ready", 32'(child_ready), 32'h0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    // Overall time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
